// File: rtl/crc_pkg.sv
// Shared definitions for the CRC encoder and the CRC checker: state
// encoding, default generator constants and the single-bit CRC step.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } crc_enc_state_t;

    // CRC-8/ATM: x^8 + x^2 + x + 1, register starts at zero
    localparam logic [7:0] CRC_POLY_DEFAULT = 8'h07;
    localparam logic [7:0] CRC_INIT_DEFAULT = 8'h00;

    // Widest CRC the shared step function handles
    localparam int CRC_MAX_W = 64;

    // One MSB-first LFSR step. Operands are left-justified in a
    // CRC_MAX_W-bit word so one function serves every CRC width: the
    // CRC MSB always sits at bit CRC_MAX_W-1 and the unused low bits
    // stay zero through the shift and the XOR.
    function automatic logic [CRC_MAX_W-1:0] crc_step(
        input logic [CRC_MAX_W-1:0] crc,
        input logic                 bit_in,
        input logic [CRC_MAX_W-1:0] poly
    );
        logic fb;
        fb = crc[CRC_MAX_W-1] ^ bit_in;
        return {crc[CRC_MAX_W-2:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/crc_lfsr.sv
// CRC register with a one-bit-per-cycle update; init has priority over step.
module crc_lfsr
    import crc_pkg::*;
#(
    parameter int               CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC_POLY_DEFAULT),
    parameter logic [CRC_W-1:0] INIT  = CRC_W'(CRC_INIT_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             step,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    localparam int PAD = CRC_MAX_W - CRC_W;

    logic [CRC_W-1:0]     crc_q;
    logic [CRC_W-1:0]     crc_d;
    logic [CRC_MAX_W-1:0] crc_ext;
    logic [CRC_MAX_W-1:0] poly_ext;
    logic [CRC_MAX_W-1:0] stepped;

    // Next CRC value: reload, advance by one data bit, or hold
    always_comb begin
        crc_ext  = CRC_MAX_W'(crc_q) << PAD;
        poly_ext = CRC_MAX_W'(POLY) << PAD;
        stepped  = crc_step(crc_ext, bit_in, poly_ext);
        crc_d    = crc_q;
        if (init) begin
            crc_d = INIT;
        end else if (step) begin
            crc_d = CRC_W'(stepped >> PAD);
        end
    end

    // CRC register, returns to INIT on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/crc_shift_encoder.sv
// Serial CRC encoder for the memory write path: captures a word, folds it
// MSB first into the CRC, emits {data, crc} once and flags mis-sequencing.
module crc_shift_encoder
    import crc_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                CRC_W  = 8,
    parameter logic [CRC_W-1:0]  POLY   = CRC_W'(CRC_POLY_DEFAULT),
    parameter logic [CRC_W-1:0]  INIT   = CRC_W'(CRC_INIT_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_en,
    input  logic                    shift_en,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    data_valid,
    output logic [DATA_W+CRC_W-1:0] codeword_out,
    output logic                    codeword_valid,
    output logic [CRC_W-1:0]        crc_out,
    output logic                    shift_done,
    output logic                    protocol_err
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    crc_enc_state_t            state_q, state_d;
    logic [DATA_W-1:0]         data_hold_q, data_hold_d;
    logic [DATA_W-1:0]         data_sr_q, data_sr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_W+CRC_W-1:0]   codeword_q, codeword_d;
    logic                      codeword_valid_q, codeword_valid_d;
    logic                      shift_done_q, shift_done_d;
    logic                      protocol_err_q, protocol_err_d;
    logic                      lfsr_init;
    logic                      lfsr_step;
    logic [CRC_W-1:0]          crc_w;

    crc_lfsr #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .INIT  (INIT)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .init   (lfsr_init),
        .step   (lfsr_step),
        .bit_in (data_sr_q[DATA_W-1]),
        .crc    (crc_w)
    );

    // Sequencing: load wins over everything; stray strobes only raise the
    // sticky error and leave state and datapath untouched
    always_comb begin
        state_d          = state_q;
        data_hold_d      = data_hold_q;
        data_sr_d        = data_sr_q;
        cnt_d            = cnt_q;
        codeword_d       = codeword_q;
        codeword_valid_d = 1'b0;
        protocol_err_d   = protocol_err_q;
        lfsr_init        = 1'b0;
        lfsr_step        = 1'b0;

        if (load_en) begin
            data_hold_d    = data_in;
            data_sr_d      = data_in;
            cnt_d          = '0;
            protocol_err_d = 1'b0;
            lfsr_init      = 1'b1;
            state_d        = ST_SHIFT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (shift_en || data_valid) begin
                        protocol_err_d = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (shift_en) begin
                        lfsr_step = 1'b1;
                        data_sr_d = {data_sr_q[DATA_W-2:0], 1'b0};
                        cnt_d     = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_d = ST_DONE;
                        end
                    end
                    if (data_valid) begin
                        protocol_err_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (data_valid) begin
                        codeword_d       = {data_hold_q, crc_w};
                        codeword_valid_d = 1'b1;
                        state_d          = ST_IDLE;
                    end
                    if (shift_en) begin
                        protocol_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        shift_done_d = (state_d == ST_DONE);
    end

    // FSM state, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            data_hold_q      <= '0;
            data_sr_q        <= '0;
            cnt_q            <= '0;
            codeword_q       <= '0;
            codeword_valid_q <= 1'b0;
            shift_done_q     <= 1'b0;
            protocol_err_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            data_hold_q      <= data_hold_d;
            data_sr_q        <= data_sr_d;
            cnt_q            <= cnt_d;
            codeword_q       <= codeword_d;
            codeword_valid_q <= codeword_valid_d;
            shift_done_q     <= shift_done_d;
            protocol_err_q   <= protocol_err_d;
        end
    end

    assign codeword_out   = codeword_q;
    assign codeword_valid = codeword_valid_q;
    assign crc_out        = crc_w;
    assign shift_done     = shift_done_q;
    assign protocol_err   = protocol_err_q;

endmodule

// File: doc/crc_shift_encoder.md
# crc_shift_encoder

Serial CRC encoder datapath on the memory write path, driven by the CRC write controller's `load_en`, `shift_en` and `data_valid` strobes. It captures a data word, folds it into a CRC one bit per `shift_en` cycle, MSB first, through an LFSR. It then presents the data-plus-CRC codeword to memory for one cycle when the controller signals `data_valid`. It also flags protocol violations by the controller, so a mis-sequenced write is visible rather than silently corrupting stored check bits.

## Interface
Parameters:
- `DATA_W`, 8: data word width in bits (≥2).
- `CRC_W`, 8: CRC width in bits (≥2).
- `POLY`, 8'h07: generator polynomial, implicit x^CRC_W term omitted (CRC-8/ATM by default).
- `INIT`, 0: CRC register value after load.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `load_en`, in, 1: capture `data_in` and start a new word.
- `shift_en`, in, 1: advance the LFSR by one data bit.
- `data_in`, in, DATA_W: write data, sampled only when `load_en` is high.
- `data_valid`, in, 1: controller request to emit the finished codeword.
- `codeword_out`, out, DATA_W+CRC_W: `{data, crc}` with the data in the MSBs.
- `codeword_valid`, out, 1: single-cycle qualifier for `codeword_out`.
- `crc_out`, out, CRC_W: live CRC register.
- `shift_done`, out, 1: all DATA_W bits have been shifted; the CRC is final.
- `protocol_err`, out, 1: sticky sequencing-error flag.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- On reset:
  - State is IDLE.
  - All registers are 0, except the CRC register, which resets to `INIT`.
  - `codeword_out` is 0, and `codeword_valid`, `shift_done` and `protocol_err` are 0.
- `load_en` in any state, with priority over everything else:
  - `data_hold` and `data_sr` load from `data_in`.
  - The CRC register loads `INIT`, and the bit count loads 0.
  - `protocol_err` is cleared, and the next state is SHIFT.
- `shift_en` in SHIFT, without `load_en`:
  - fb = `crc[CRC_W-1] ^ data_sr[DATA_W-1]`.
  - crc ← `{crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)`.
  - `data_sr` shifts left by one, and the count increments.
  - When the count reaches DATA_W, the next state is DONE.
- Bit count width is $clog2(DATA_W+1). The count never exceeds DATA_W.
- `shift_done` is 1 exactly while the state is DONE.
- `data_valid` in DONE, without `load_en`:
  - `codeword_out` ← `{data_hold, crc}`.
  - `codeword_valid` = 1 for the next cycle only.
  - The next state is IDLE.
- `codeword_out` holds its value until the next emit or a reset.
- Errors (each sets `protocol_err`; the state and datapath are unchanged):
  - `shift_en` while in IDLE or DONE.
  - `data_valid` while in IDLE or SHIFT.
- Simultaneous events:
  - `shift_en` and `data_valid` together in DONE: the emit proceeds, and the stray `shift_en` sets `protocol_err`.
  - `shift_en` and `data_valid` together in SHIFT: the shift proceeds, and `data_valid` sets `protocol_err`.
  - `load_en` with any other strobe: only the load takes effect.
- Reset mid-word aborts the word immediately. No codeword is emitted, and the next word needs a new `load_en`.

## Timing
- `load_en` sampled at edge N: the state is SHIFT from N+1, and `crc_out` = `INIT`.
- With `shift_en` continuous from edge N+1:
  - The state is DONE and `shift_done` = 1 after edge N+DATA_W.
  - The load-to-done latency is DATA_W+1 cycles.
- `shift_en` may gap: the LFSR holds during any gap, and the result is independent of the gap pattern.
- `data_valid` sampled at edge M in DONE: `codeword_valid` is high during cycle M+1 only, and `shift_done` drops at M+1.
- There is no backpressure. The controller must not assert `load_en` before the codeword is consumed.
- `protocol_err` is registered: it rises one edge after the offending strobe and stays high until the next `load_en` or reset.

## Structure
- A shared package `crc_pkg` holds:
  - the state encoding `crc_enc_state_t` (IDLE=0, SHIFT=1, DONE=2);
  - the default `POLY`/`INIT` constants;
  - the function `crc_step(crc, bit, poly)`, which the future CRC checker also uses.
- One sub-module `crc_lfsr` contains the CRC register plus its one-bit step, with inputs init/step/bit.
- FSM, counter, data registers and error logic live in the top module.

## Test plan
- Reset, load 8'h01, 8 consecutive `shift_en`, then `data_valid`:
  - `crc_out` = 8'h07;
  - `codeword_out` = 16'h0107 with a single-cycle `codeword_valid`.
- Load 8'hFF, shift 8 times with idle cycles between shifts:
  - `crc_out` = 8'hF3;
  - `shift_done` rises only after the 8th shift.
- Load 8'h80, shift 8 times:
  - `crc_out` = 8'h89;
  - `shift_done` is high from the edge after the 8th shift until `data_valid`.
- `shift_en` in IDLE, and `data_valid` after only 3 shifts:
  - `protocol_err` = 1 and the CRC is unchanged;
  - the next `load_en` clears `protocol_err`.
- Assert `rst` after 4 shifts of 8'hFF:
  - all outputs return to reset values immediately;
  - a subsequent `data_valid` yields no `codeword_valid`.
- Load 8'h01 in the same cycle as `shift_en`, then 8 shifts:
  - only the load takes effect, and the final `crc_out` = 8'h07.
